// File: rtl/alu_bist_driver.sv
// alu_bist_driver: LFSR-driven self-test engine for a 16-bit combinational ALU.
// Sweeps opCode with pseudo-random operands and folds every result into a MISR signature.
module alu_bist_driver #(
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] SEED_A        = 16'hACE1,
  parameter logic [15:0] SEED_B        = 16'h1D87,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] input1,
  output logic [15:0] input2,
  output logic [2:0]  opCode,
  input  logic [15:0] outputALU,
  input  logic        zeroOutput,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  localparam int CW = $clog2(NUM_VECTORS) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1) + 1;
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [15:0] SA = (SEED_A == 16'h0) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SB = (SEED_B == 16'h0) ? 16'h0001 : SEED_B;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CAPTURE, DONE} state_t;
  state_t        state_q;
  logic [15:0]   lfsr_a_q, lfsr_b_q, sig_q, in1_q, in2_q;
  logic [15:0]   lfsr_a_d, lfsr_b_d, sig_d;
  logic [2:0]    op_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] settle_q;
  logic          busy_q, done_q, pass_q;
  always_comb begin
    lfsr_a_d = {lfsr_a_q[14:0], lfsr_a_q[15] ^ lfsr_a_q[13] ^ lfsr_a_q[12] ^ lfsr_a_q[10]};
    lfsr_b_d = {lfsr_b_q[14:0], lfsr_b_q[15] ^ lfsr_b_q[13] ^ lfsr_b_q[12] ^ lfsr_b_q[10]};
    sig_d    = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]} ^ outputALU ^ {15'b0, zeroOutput};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_a_q <= SA;
      lfsr_b_q <= SB;
      sig_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      op_q     <= '0;
      count_q  <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q  <= DRIVE;
          lfsr_a_q <= SA;
          lfsr_b_q <= SB;
          sig_q    <= '0;
          count_q  <= '0;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          pass_q   <= 1'b0;
        end
        DRIVE: begin
          in1_q    <= lfsr_a_q;
          in2_q    <= lfsr_b_q;
          op_q     <= count_q[2:0];
          settle_q <= SW'(SETTLE_CYCLES - 1);
          state_q  <= (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
        end
        SETTLE: begin
          settle_q <= settle_q - 1'b1;
          state_q  <= (settle_q == '0) ? CAPTURE : SETTLE;
        end
        CAPTURE: begin
          sig_q    <= sig_d;
          lfsr_a_q <= lfsr_a_d;
          lfsr_b_q <= lfsr_b_d;
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(NUM_VECTORS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (sig_d == GOLDEN_SIG);
          end else begin
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign input1    = in1_q;
  assign input2    = in2_q;
  assign opCode    = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
endmodule

// File: tb/tb_alu_bist_driver.sv
// tb_alu_bist_driver: directed checks of the BIST driver against stub and reference ALUs.
module tb_alu_bist_driver;
  logic        clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] in1_0, in2_0, alu0, sig0, in1_1, in2_1, alu1, sig1;
  logic [2:0]  op0, op1;
  logic        z0, z1, busy0, done0, pass0, busy1, done1, pass1;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic logic [15:0] model_sig(input int nv);
    logic [15:0] a, b, s, r;
    a = 16'hACE1; b = 16'h1D87; s = 16'h0;
    for (int i = 0; i < nv; i++) begin
      r = alu_f(a, b, 3'(i));
      s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ r ^ {15'b0, r == 16'h0};
      a = lfsr_step(a);
      b = lfsr_step(b);
    end
    return s;
  endfunction
  assign alu0 = (mode == 2'd2) ? alu_f(in1_0, in2_0, op0) : 16'h0;
  assign z0   = (mode == 2'd1) || (mode == 2'd2 && alu0 == 16'h0);
  assign alu1 = alu_f(in1_1, in2_1, op1);
  assign z1   = (alu1 == 16'h0);
  alu_bist_driver #(.NUM_VECTORS(4), .SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .input1(in1_0), .input2(in2_0), .opCode(op0),
    .outputALU(alu0), .zeroOutput(z0), .busy(busy0), .done(done0), .pass(pass0), .signature(sig0));
  alu_bist_driver #(.NUM_VECTORS(20), .SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .input1(in1_1), .input2(in2_1), .opCode(op1),
    .outputALU(alu1), .zeroOutput(z1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));
  logic [2:0] ops [4];
  task automatic run0(input bit glitch, output int n);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
      start0 = glitch && (n % 3 == 1);
      if (n % 3 == 1 && n / 3 < 4) ops[n / 3] = op0;
    end
    start0 = 1'b0;
  endtask
  task automatic run1(output int n);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    n = 0;
    while (busy1 && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({in1_0, in2_0, op0, busy0, done0, pass0, sig0} !== '0) begin
      failures++;
      $display("FAIL reset_init got %h %h %h %b%b%b %h want all 0", in1_0, in2_0, op0, busy0, done0, pass0, sig0);
    end
    @(negedge clk) rst = 1'b0;
    mode = 2'd0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in1_0, in2_0, op0, busy0, done0, pass0, sig0} !== '0) begin
      failures++;
      $display("FAIL reset_midrun got %h %h %h %b%b%b %h want all 0", in1_0, in2_0, op0, busy0, done0, pass0, sig0);
    end
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_first_vectors;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL busy_after_start got %b want 1", busy0); end
    @(negedge clk);
    checks++;
    if ({in1_0, in2_0, op0} !== {16'hACE1, 16'h1D87, 3'd0}) begin
      failures++;
      $display("FAIL vec0 got %h %h %0d want ace1 1d87 0", in1_0, in2_0, op0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({in1_0, op0} !== {16'h59C3, 3'd1}) begin
      failures++;
      $display("FAIL vec1 got %h %0d want 59c3 1", in1_0, op0);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done0 !== 1'b1) begin failures++; $display("FAIL restart_done got %b want 1", done0); end
  endtask
  task automatic test_run_length;
    int n;
    run0(1'b0, n);
    checks++;
    if (n !== 12) begin failures++; $display("FAIL busy_len got %0d want 12", n); end
    checks++;
    if ({done0, busy0} !== 2'b10) begin failures++; $display("FAIL done_busy got %b%b want 10", done0, busy0); end
    checks++;
    if ({ops[0], ops[1], ops[2], ops[3]} !== {3'd0, 3'd1, 3'd2, 3'd3}) begin
      failures++;
      $display("FAIL opcode_seq got %0d %0d %0d %0d want 0 1 2 3", ops[0], ops[1], ops[2], ops[3]);
    end
  endtask
  task automatic test_signature;
    int n;
    mode = 2'd0;
    run0(1'b0, n);
    checks++;
    if ({sig0, pass0, done0} !== {16'h0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sig_zero got %h pass=%b done=%b want 0000 1 1", sig0, pass0, done0);
    end
    mode = 2'd1;
    run0(1'b0, n);
    checks++;
    if ({sig0, pass0} !== {16'h000F, 1'b0}) begin
      failures++;
      $display("FAIL sig_zflag got %h pass=%b want 000f 0", sig0, pass0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({sig0, op0, done0} !== {16'h000F, 3'd3, 1'b1}) begin
      failures++;
      $display("FAIL done_hold got %h op=%0d done=%b want 000f 3 1", sig0, op0, done0);
    end
  endtask
  task automatic test_start_during_busy;
    int n;
    mode = 2'd1;
    run0(1'b1, n);
    checks++;
    if ({n, sig0} !== {32'd12, 16'h000F}) begin
      failures++;
      $display("FAIL glitch_run got len=%0d sig=%h want 12 000f", n, sig0);
    end
  endtask
  task automatic test_back_to_back;
    int n;
    logic [15:0] first, want;
    want = model_sig(20);
    run1(n);
    first = sig1;
    checks++;
    if (n !== 40) begin failures++; $display("FAIL settle0_len got %0d want 40", n); end
    checks++;
    if ({sig1, pass1} !== {want, want == 16'h0}) begin
      failures++;
      $display("FAIL real_sig got %h pass=%b want %h %b", sig1, pass1, want, want == 16'h0);
    end
    run1(n);
    checks++;
    if ({n, sig1} !== {32'd40, first}) begin
      failures++;
      $display("FAIL rerun got len=%0d sig=%h want 40 %h", n, sig1, first);
    end
    mode = 2'd2;
    run0(1'b0, n);
    first = sig0;
    run0(1'b0, n);
    checks++;
    if ({sig0, first} !== {model_sig(4), model_sig(4)}) begin
      failures++;
      $display("FAIL real_sig4 got %h then %h want %h", first, sig0, model_sig(4));
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({done0, pass0, sig0, done1, sig1} !== '0) begin
      failures++;
      $display("FAIL reset_done got done=%b pass=%b sig=%h done1=%b sig1=%h want 0", done0, pass0, sig0, done1, sig1);
    end
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    test_reset;
    test_first_vectors;
    test_run_length;
    test_signature;
    test_start_during_busy;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
